// File: rtl/fifo_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl_if
// Read-side bus of the async FIFO, between the read-domain controller and
// whatever consumes the FIFO in the rclk domain.
//   read_enable      consumer -> controller  read request
//   read_data        controller -> consumer  registered read data (1-cycle latency)
//   rdempty          controller -> consumer  FIFO empty
//   rd_almost_empty  controller -> consumer  level <= almost-empty threshold
//   underflow        controller -> consumer  one-cycle pulse, read while empty
//   fifo_read_count  controller -> consumer  successful reads since reset (wraps)
//   rd_level         controller -> consumer  occupancy seen by the read domain
// Modports: master = consumer, slave = controller.
// -----------------------------------------------------------------------------
interface fifo_read_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
);
    logic                    read_enable;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    rdempty;
    logic                    rd_almost_empty;
    logic                    underflow;
    logic [ADDRESS_WIDTH:0]  fifo_read_count;
    logic [ADDRESS_WIDTH:0]  rd_level;

    modport master (
        output read_enable,
        input  read_data, rdempty, rd_almost_empty, underflow,
               fifo_read_count, rd_level
    );

    modport slave (
        input  read_enable,
        output read_data, rdempty, rd_almost_empty, underflow,
               fifo_read_count, rd_level
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
// Read-domain controller of an async FIFO (rclk domain). Synchronises the Gray
// write pointer, owns the read pointer, drives the memory read port and
// produces the read-side status flags. The registered Gray read pointer is
// exported back to the write domain.
// Ports:
//   rclk          read clock, all logic on posedge
//   hw_rst_n      synchronous active-low reset
//   rd_bus        read-side bus (slave modport), see fifo_read_ctrl_if
//   aempty_value  almost-empty threshold in entries
//   wptr_gray     Gray write pointer from the wclk domain (unsynchronised)
//   mem_rdata     memory data at mem_raddr (combinational read)
//   mem_raddr     memory read address
//   mem_ren       memory read strobe, high on an accepted read
//   rptr_gray     registered Gray read pointer, to the write domain
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                      rclk,
    input  logic                      hw_rst_n,
    fifo_read_ctrl_if.slave           rd_bus,
    input  logic [ADDRESS_WIDTH-1:0]  aempty_value,
    input  logic [ADDRESS_WIDTH:0]    wptr_gray,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [ADDRESS_WIDTH-1:0]  mem_raddr,
    output logic                      mem_ren,
    output logic [ADDRESS_WIDTH:0]    rptr_gray
);
    localparam int AW = ADDRESS_WIDTH;

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0] sync_q [SYNC_STAGES];
    logic [AW:0] wq;
    logic [AW:0] wbin;
    logic [AW:0] rbin;
    logic [AW:0] rbin_next;
    logic [AW:0] rgray_next;
    logic [AW:0] level_next;
    logic        rd_fire;

    assign wq   = sync_q[SYNC_STAGES-1];
    assign wbin = gray2bin(wq);

    // Gating with hw_rst_n keeps a read in the reset cycle from strobing the
    // memory while the registered rdempty still shows the pre-reset state.
    assign rd_fire    = rd_bus.read_enable & ~rd_bus.rdempty & hw_rst_n;
    assign rbin_next  = rbin + {{AW{1'b0}}, rd_fire};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    // Uses the synchronised (stale) write pointer, so the level can only be
    // under-reported while the writer is advancing.
    assign level_next = wbin - rbin_next;

    assign mem_raddr = rbin[AW-1:0];
    assign mem_ren   = rd_fire;

    always_ff @(posedge rclk) begin
        if (!hw_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            rbin                   <= '0;
            rptr_gray              <= '0;
            rd_bus.read_data       <= '0;
            rd_bus.rdempty         <= 1'b1;
            rd_bus.rd_almost_empty <= 1'b1;
            rd_bus.underflow       <= 1'b0;
            rd_bus.fifo_read_count <= '0;
            rd_bus.rd_level        <= '0;
        end else begin
            sync_q[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rbin      <= rbin_next;
            rptr_gray <= rgray_next;
            if (rd_fire) begin
                rd_bus.read_data <= mem_rdata;
            end
            // Full (equal addresses, differing MSB) never compares equal here.
            rd_bus.rdempty         <= (rgray_next == wq);
            rd_bus.rd_level        <= level_next;
            rd_bus.rd_almost_empty <= (level_next <= {1'b0, aempty_value});
            rd_bus.underflow       <= rd_bus.read_enable & rd_bus.rdempty;
            rd_bus.fifo_read_count <= rd_bus.fifo_read_count + {{AW{1'b0}}, rd_fire};
        end
    end
endmodule
